// File: rtl/vlc_link_ctrl.sv
// VLC link controller: arbitrates the optical line between the PWM idle waveform and the
// encoder, issues TX FIFO bytes to the encoder, and pushes decoded bytes into the RX FIFO.
module vlc_link_ctrl #(
  parameter int DATA_W     = 8,
  parameter int PWM_W      = 8,
  parameter int HS_CYCLES  = 850,
  parameter int GAP_CYCLES = 600,
  parameter int MAX_BURST  = 16,
  parameter int DROP_W     = 8
) (
  input  logic              pclk,
  input  logic              resetn,
  input  logic              pwm_en,
  input  logic [PWM_W-1:0]  pwm_period,
  input  logic [PWM_W-1:0]  pwm_duty,
  input  logic [DATA_W-1:0] tx_rdata,
  input  logic              tx_rempty,
  output logic              tx_rinc,
  output logic              enc_encode,
  output logic [DATA_W-1:0] enc_data,
  input  logic              enc_ready,
  input  logic              enc_busy,
  input  logic              enc_tx,
  input  logic              enc_break,
  output logic              tx,
  input  logic [DATA_W-1:0] dec_data,
  input  logic              dec_valid,
  output logic [DATA_W-1:0] rx_wdata,
  output logic              rx_winc,
  input  logic              rx_wfull,
  output logic [DROP_W-1:0] rx_drop_cnt,
  output logic [2:0]        tx_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam int WAIT_MAX = (HS_CYCLES > GAP_CYCLES) ? HS_CYCLES : GAP_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int BURST_W  = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  localparam logic [WAIT_W-1:0]  HS_LAST   = WAIT_W'(HS_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  GAP_LAST  = WAIT_W'(GAP_CYCLES - 1);
  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

  logic [2:0]         state;
  logic [2:0]         state_next;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic               burst_hit;
  logic               issue;
  logic [PWM_W-1:0]   pwm_cnt;
  logic               pwm_out;

  logic               rx_vld_p1;
  logic [DATA_W-1:0]  rx_data_p1;
  logic [DROP_W-1:0]  drop_cnt_p1;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // PWM idle waveform; frozen while the encoder owns the line
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt <= '0;
    end else if (pwm_en && !enc_busy) begin
      if (pwm_cnt == pwm_period) pwm_cnt <= '0;
      else                       pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign pwm_out = pwm_en & (pwm_cnt < pwm_duty);
  assign tx      = enc_busy ? enc_tx : pwm_out;

  assign burst_hit = (MAX_BURST != 0) && (burst_cnt == BURST_LIM);

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (!tx_rempty) state_next = pwm_out ? S_LOAD : S_PREP;
      S_PREP: if (wait_cnt == HS_LAST) state_next = S_LOAD;
      S_LOAD: begin
        if (tx_rempty)      state_next = S_IDLE;
        else if (enc_ready) state_next = S_SEND;
      end
      S_SEND: begin
        if (enc_break)                    state_next = S_GAP;
        else if (burst_hit && enc_ready)  state_next = S_GAP;
        else if (enc_ready && tx_rempty)  state_next = S_IDLE;
      end
      S_GAP:  if (wait_cnt == GAP_LAST) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Issue is Mealy: the pop and the encode strobe share one combinational decision
  always_comb begin
    issue = 1'b0;
    case (state)
      S_LOAD:  issue = enc_ready & ~tx_rempty;
      S_SEND:  issue = ~enc_break & ~burst_hit & enc_ready & ~tx_rempty;
      default: issue = 1'b0;
    endcase
  end

  assign enc_encode = issue;
  assign tx_rinc    = issue;
  assign enc_data   = tx_rdata;
  assign tx_state   = state;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (state == S_PREP || state == S_GAP) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      burst_cnt <= '0;
    end else if (state_next == S_IDLE || state_next == S_GAP) begin
      burst_cnt <= '0;
    end else if (issue) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // RX stage p1: one-cycle registered write into the RX FIFO
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      rx_vld_p1   <= 1'b0;
      rx_data_p1  <= '0;
      drop_cnt_p1 <= '0;
    end else begin
      rx_vld_p1 <= dec_valid & ~rx_wfull;
      if (dec_valid && !rx_wfull) rx_data_p1  <= dec_data;
      if (dec_valid && rx_wfull)  drop_cnt_p1 <= sat_inc(drop_cnt_p1);
    end
  end

  assign rx_winc     = rx_vld_p1;
  assign rx_wdata    = rx_data_p1;
  assign rx_drop_cnt = drop_cnt_p1;

endmodule

// File: tb/tb_vlc_link_ctrl.sv
// Directed bench for vlc_link_ctrl: PWM idle, line-high/low frame start, burst limit,
// break gap, RX overflow and mid-frame reset.
module tb_vlc_link_ctrl;

  logic       pclk = 1'b0;
  logic       resetn;
  logic       pwm_en;
  logic [7:0] pwm_period;
  logic [7:0] pwm_duty;
  logic [7:0] tx_rdata;
  logic       tx_rempty;
  logic       tx_rinc;
  logic       enc_encode;
  logic [7:0] enc_data;
  logic       enc_ready;
  logic       enc_busy;
  logic       enc_tx;
  logic       enc_break;
  logic       tx;
  logic [7:0] dec_data;
  logic       dec_valid;
  logic [7:0] rx_wdata;
  logic       rx_winc;
  logic       rx_wfull;
  logic [7:0] rx_drop_cnt;
  logic [2:0] tx_state;

  logic [7:0] q[$];
  int         n_total = 0;
  int         n_pass  = 0;
  int         n_fail  = 0;
  int         n_issue = 0;
  int         n_bad   = 0;
  logic [7:0] last_byte = 8'h00;

  always #5 pclk = ~pclk;

  vlc_link_ctrl #(
    .DATA_W(8), .PWM_W(8), .HS_CYCLES(850), .GAP_CYCLES(600), .MAX_BURST(4), .DROP_W(8)
  ) dut (
    .pclk(pclk), .resetn(resetn), .pwm_en(pwm_en), .pwm_period(pwm_period),
    .pwm_duty(pwm_duty), .tx_rdata(tx_rdata), .tx_rempty(tx_rempty), .tx_rinc(tx_rinc),
    .enc_encode(enc_encode), .enc_data(enc_data), .enc_ready(enc_ready), .enc_busy(enc_busy),
    .enc_tx(enc_tx), .enc_break(enc_break), .tx(tx), .dec_data(dec_data),
    .dec_valid(dec_valid), .rx_wdata(rx_wdata), .rx_winc(rx_winc), .rx_wfull(rx_wfull),
    .rx_drop_cnt(rx_drop_cnt), .tx_state(tx_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_sync();
    tx_rempty = (q.size() == 0);
    tx_rdata  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock: note any pop before the edge, retire it from the FIFO model after the edge
  task automatic tick();
    logic pop;
    #1;
    pop = tx_rinc;
    if (pop) begin
      n_issue++;
      last_byte = enc_data;
      if (!enc_encode || tx_rempty || enc_data !== tx_rdata) n_bad++;
    end else if (enc_encode) begin
      n_bad++;
    end
    @(posedge pclk);
    #1;
    if (pop && q.size() != 0) void'(q.pop_front());
    fifo_sync();
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         base;
    logic [19:0] pat;
    logic       winc_seen;

    resetn = 1'b0; pwm_en = 1'b1; pwm_period = 8'd9; pwm_duty = 8'd3;
    enc_ready = 1'b0; enc_busy = 1'b0; enc_tx = 1'b0; enc_break = 1'b0;
    dec_data = 8'h00; dec_valid = 1'b0; rx_wfull = 1'b0;
    fifo_sync();
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_state", tx_state, 0);
    chk("rst_rinc", tx_rinc, 0);
    chk("rst_encode", enc_encode, 0);
    chk("rst_winc", rx_winc, 0);
    chk("rst_wdata", rx_wdata, 0);
    chk("rst_drop", rx_drop_cnt, 0);
    chk("rst_tx_pwm", tx, 1);

    // PWM idle: period 9, duty 3 -> 3 high, 7 low
    resetn = 1'b1;
    #1;
    for (int k = 0; k < 20; k++) begin
      pat[k] = tx;
      tick();
    end
    chk("pwm_pattern", pat, 20'h01C07);
    pwm_period = 8'd0; pwm_duty = 8'd1;
    #1;
    chk("pwm_p0_high", tx, 1);
    repeat (3) tick();
    chk("pwm_p0_hold", tx, 1);
    pwm_en = 1'b0;
    #1;
    chk("pwm_off_low", tx, 0);

    // Line-high start
    pwm_en = 1'b1; pwm_period = 8'd9; pwm_duty = 8'd3; enc_ready = 1'b1;
    base = n_issue;
    q.push_back(8'hA5);
    fifo_sync();
    tick();
    chk("hi_load_state", tx_state, 2);
    chk("hi_load_rinc", tx_rinc, 1);
    chk("hi_load_encode", enc_encode, 1);
    chk("hi_load_data", enc_data, 8'hA5);
    tick();
    chk("hi_send_state", tx_state, 3);
    chk("hi_send_rinc", tx_rinc, 0);
    tick();
    chk("hi_idle_state", tx_state, 0);
    chk("hi_issues", n_issue - base, 1);

    // Line-low start: 850 cycles of PREP
    pwm_en = 1'b0;
    q.push_back(8'h3C);
    fifo_sync();
    tick();
    chk("lo_prep_state", tx_state, 1);
    n = 0;
    while (tx_state == 3'd1 && n < 2000) begin
      tick();
      n++;
    end
    chk("lo_prep_len", n, 850);
    chk("lo_load_state", tx_state, 2);
    chk("lo_load_rinc", tx_rinc, 1);
    chk("lo_load_data", enc_data, 8'h3C);
    tick();
    chk("lo_send_state", tx_state, 3);
    enc_busy = 1'b1; enc_tx = 1'b1; pwm_en = 1'b1; pwm_duty = 8'd4;
    #1;
    chk("busy_tx_hi", tx, 1);
    enc_tx = 1'b0;
    #1;
    chk("busy_tx_lo", tx, 0);
    repeat (5) tick();
    chk("busy_idle_state", tx_state, 0);
    enc_busy = 1'b0;
    #1;
    chk("pwm_frozen", tx, 1);
    tick();
    chk("pwm_resumed", tx, 0);

    // Burst limit of 4 with a pulsing encoder ready; duty > period keeps the line high
    pwm_duty = 8'd10;
    base = n_issue;
    for (int b = 1; b <= 6; b++) q.push_back(8'(b));
    fifo_sync();
    enc_ready = 1'b0;
    n = 0;
    while (tx_state != 3'd4 && n < 200) begin
      enc_ready = ~enc_ready;
      tick();
      n++;
    end
    chk("burst_gap_state", tx_state, 4);
    chk("burst_issues", n_issue - base, 4);
    chk("burst_left", q.size(), 2);
    n = 0;
    while (tx_state == 3'd4 && n < 2000) begin
      enc_ready = ~enc_ready;
      tick();
      n++;
    end
    chk("gap_len", n, 600);
    chk("gap_idle_state", tx_state, 0);
    n = 0;
    while ((q.size() != 0 || tx_state != 3'd0) && n < 200) begin
      enc_ready = ~enc_ready;
      tick();
      n++;
    end
    chk("burst_total", n_issue - base, 6);
    chk("burst_last", last_byte, 8'h06);

    // Encoder break forces a gap after only one byte
    enc_ready = 1'b1;
    base = n_issue;
    q.push_back(8'h77);
    q.push_back(8'h88);
    fifo_sync();
    tick();
    tick();
    chk("brk_send_state", tx_state, 3);
    enc_break = 1'b1;
    #1;
    chk("brk_no_issue", tx_rinc, 0);
    tick();
    enc_break = 1'b0;
    chk("brk_gap_state", tx_state, 4);
    chk("brk_issues", n_issue - base, 1);
    n = 0;
    while ((q.size() != 0 || tx_state != 3'd0) && n < 1000) begin
      tick();
      n++;
    end
    chk("brk_total", n_issue - base, 2);
    chk("brk_last", last_byte, 8'h88);

    // RX path and overflow saturation
    dec_data = 8'h11; dec_valid = 1'b1; rx_wfull = 1'b0;
    tick();
    chk("rx_winc", rx_winc, 1);
    chk("rx_wdata", rx_wdata, 8'h11);
    dec_valid = 1'b0;
    tick();
    chk("rx_winc_off", rx_winc, 0);
    chk("rx_wdata_hold", rx_wdata, 8'h11);
    rx_wfull = 1'b1; dec_valid = 1'b1; dec_data = 8'h22;
    tick();
    chk("rx_drop_one", rx_drop_cnt, 1);
    chk("rx_full_nowinc", rx_winc, 0);
    winc_seen = 1'b0;
    repeat (299) begin
      tick();
      if (rx_winc) winc_seen = 1'b1;
    end
    chk("rx_full_winc_seen", winc_seen, 0);
    chk("rx_drop_sat", rx_drop_cnt, 8'hFF);
    chk("rx_wdata_kept", rx_wdata, 8'h11);
    dec_valid = 1'b0; rx_wfull = 1'b0;

    // Reset in the middle of a frame
    base = n_issue;
    q.push_back(8'h5A);
    q.push_back(8'h6B);
    fifo_sync();
    enc_ready = 1'b1;
    tick();
    tick();
    chk("rs_send_state", tx_state, 3);
    enc_ready = 1'b0; dec_valid = 1'b1; dec_data = 8'h99;
    tick();
    dec_valid = 1'b0;
    chk("rs_pre_winc", rx_winc, 1);
    chk("rs_pre_state", tx_state, 3);
    enc_ready = 1'b1;
    resetn = 1'b0;
    #1;
    chk("rs_state", tx_state, 0);
    chk("rs_rinc", tx_rinc, 0);
    chk("rs_encode", enc_encode, 0);
    chk("rs_winc", rx_winc, 0);
    chk("rs_wdata", rx_wdata, 0);
    chk("rs_drop", rx_drop_cnt, 0);
    tick();
    tick();
    chk("rs_hold_state", tx_state, 0);
    resetn = 1'b1;
    tick();
    chk("rs_restart_state", tx_state, 2);
    chk("rs_restart_data", enc_data, 8'h6B);
    chk("rs_restart_rinc", tx_rinc, 1);
    tick();
    tick();
    chk("rs_end_state", tx_state, 0);
    chk("rs_issues", n_issue - base, 2);
    chk("rs_fifo_empty", q.size(), 0);

    chk("pop_integrity", n_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
